// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered NZCV flags and an iterative shift-add multiplier
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic             busy,
  output logic             done
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  logic [0:0]         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_nx;
  logic [WIDTH-1:0]   mplier_q, mplier_d, result_q, result_d, bx, r;
  logic [3:0]         flags_q, flags_d;
  logic [SW-1:0]      cnt_q, cnt_d, s;
  logic               done_q, done_d, c, v;
  logic [WIDTH:0]     sum, shl_w, shr_w;
  always_comb begin
    s     = b[SW-1:0];
    bx    = ALUControl[0] ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, ALUControl[0]};
    shl_w = {1'b0, a} << s;
    shr_w = {a, 1'b0} >> s;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (ALUControl)
      3'b000, 3'b001: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        // bx already carries the inverted b for sub, so one overflow rule covers both
        v = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b110: {c, r} = shl_w;
      3'b111: {r, c} = shr_w;
      default: r = '0;
    endcase
  end
  always_comb begin
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    if (state_q == IDLE && start) begin
      if (ALUControl == 3'b101 && MUL_EN) begin
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = MUL;
      end else begin
        result_d = r;
        flags_d  = {r[WIDTH-1], r == '0, c, v};
        done_d   = 1'b1;
      end
    end else if (state_q == MUL) begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == SW'(WIDTH - 1)) begin
        result_d = acc_nx[WIDTH-1:0];
        flags_d  = {acc_nx[WIDTH-1], acc_nx[WIDTH-1:0] == '0, |acc_nx[2*WIDTH-1:WIDTH], 1'b0};
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end
  assign Result   = result_q;
  assign ALUFlags = flags_q;
  assign busy     = state_q == MUL;
  assign done     = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; expected {flags,result} queued at drive, popped on done
module tb_alu_seq;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  op = '0;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;
  logic        busy, done;
  int          checks = 0, errors = 0;
  logic [35:0] exp_q[$];
  logic [35:0] e;
  logic [31:0] last_res = '0;

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(op),
    .Result(Result), .ALUFlags(ALUFlags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
  endtask

  function automatic logic [35:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s33;
    logic [63:0] p;
    logic [31:0] r;
    logic        c, v;
    int          sh;
    sh = int'(y[4:0]);
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (o)
      3'd0: begin s33 = {1'b0, x} + {1'b0, y}; r = s33[31:0]; c = s33[32]; v = (x[31] == y[31]) && (r[31] != x[31]); end
      3'd1: begin r = x - y; c = (x >= y); v = (x[31] != y[31]) && (r[31] != x[31]); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; c = (p[63:32] != 0); end
      3'd6: begin r = x << sh; c = (sh == 0) ? 1'b0 : x[32-sh]; end
      default: begin r = x >> sh; c = (sh == 0) ? 1'b0 : x[sh-1]; end
    endcase
    return {r[31], r == 0, c, v, r};
  endfunction

  task automatic test_reset;
    step;
    step;
    checks++;
    if ({Result, ALUFlags, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state: got res=%h flags=%b busy=%b done=%b, want all zero", Result, ALUFlags, busy, done);
    end
    reset = 1'b0;
    step;
  endtask

  task automatic test_add;
    drive(3'd0, 32'd10, 32'd5);
    exp_q.push_back({4'b0000, 32'd15});
    step;
    start = 1'b0;
    e = exp_q.pop_front();
    last_res = e[31:0];
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {ALUFlags, Result} !== e) begin
      errors++;
      $display("FAIL add_basic: got done=%b busy=%b %b/%h, want done=1 busy=0 %b/%h", done, busy, ALUFlags, Result, e[35:32], e[31:0]);
    end
    step;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_flags;
    logic [2:0]  ops[7]  = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd6, 3'd7, 3'd2};
    logic [31:0] as[7]   = '{32'd5, 32'd10, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h80000001, 32'hFF00FF00};
    logic [31:0] bs[7]   = '{32'd10, 32'd10, 32'd1, 32'd1, 32'd31, 32'd1, 32'h0F0F0F0F};
    logic [35:0] want[7] = '{{4'b1000, 32'hFFFFFFFB}, {4'b0110, 32'd0}, {4'b1001, 32'h80000000},
                             {4'b0110, 32'd0}, {4'b1000, 32'h80000000}, {4'b0010, 32'h40000000},
                             {4'b0000, 32'h0F000F00}};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], as[i], bs[i]);
      exp_q.push_back(want[i]);
      step;
      start = 1'b0;
      e = exp_q.pop_front();
      last_res = e[31:0];
      checks++;
      if (done !== 1'b1 || {ALUFlags, Result} !== e) begin
        errors++;
        $display("FAIL flags_%0d: got done=%b %b/%h, want done=1 %b/%h", i, done, ALUFlags, Result, e[35:32], e[31:0]);
      end
    end
    step;
  endtask

  task automatic test_mul;
    int n = 0;
    bit seen = 0, hold_bad = 0;
    drive(3'd5, 32'd7, 32'd6);
    exp_q.push_back({4'b0000, 32'd42});
    step;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mul_accept: got busy=%b done=%b, want 1/0", busy, done);
    end
    while (!seen && n < 100) begin
      if (n == 9) drive(3'd0, 32'd1, 32'd1);
      step;
      start = 1'b0;
      n++;
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1 || Result !== last_res) hold_bad = 1;
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL mul_hold: busy dropped or Result changed before done, want Result held at %h", last_res);
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL mul_latency: got %0d cycles, want 32", n);
    end
    e = exp_q.pop_front();
    last_res = e[31:0];
    checks++;
    if (busy !== 1'b0 || {ALUFlags, Result} !== e) begin
      errors++;
      $display("FAIL mul_7x6: got busy=%b %b/%h, want busy=0 %b/%h", busy, ALUFlags, Result, e[35:32], e[31:0]);
    end
    step;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_ignored_start: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    drive(3'd5, 32'h00010000, 32'h00010000);
    exp_q.push_back({4'b0110, 32'd0});
    step;
    start = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      step;
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || {ALUFlags, Result} !== e) begin
      errors++;
      $display("FAIL mul_wrap: got done=%b %b/%h after %0d cycles, want done=1 %b/%h", done, ALUFlags, Result, n, e[35:32], e[31:0]);
    end
    drive(3'd0, 32'd1, 32'd1);
    exp_q.push_back({4'b0000, 32'd2});
    step;
    start = 1'b0;
    e = exp_q.pop_front();
    last_res = e[31:0];
    checks++;
    if (done !== 1'b1 || {ALUFlags, Result} !== e) begin
      errors++;
      $display("FAIL b2b_add: got done=%b %b/%h, want done=1 %b/%h", done, ALUFlags, Result, e[35:32], e[31:0]);
    end
    step;
  endtask

  task automatic test_random;
    logic [2:0] alu_ops[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [2:0] o;
    logic [31:0] x, y;
    int n;
    bit bad = 0;
    for (int i = 0; i < 16; i++) begin
      o = alu_ops[$urandom_range(0, 6)];
      x = $urandom;
      y = (i % 4 == 0) ? 32'd0 : $urandom;
      drive(o, x, y);
      exp_q.push_back(model(o, x, y));
      step;
      e = exp_q.pop_front();
      if (done !== 1'b1 || {ALUFlags, Result} !== e) begin
        bad = 1;
        $display("FAIL rand_alu_%0d: op=%0d a=%h b=%h got done=%b %b/%h, want %b/%h", i, o, x, y, done, ALUFlags, Result, e[35:32], e[31:0]);
      end
    end
    start = 1'b0;
    checks++;
    if (bad) errors++;
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      drive(3'd5, x, y);
      exp_q.push_back(model(3'd5, x, y));
      step;
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
        step;
        n++;
      end
      e = exp_q.pop_front();
      last_res = e[31:0];
      checks++;
      if (done !== 1'b1 || n != 32 || {ALUFlags, Result} !== e) begin
        errors++;
        $display("FAIL rand_mul_%0d: a=%h b=%h got %b/%h after %0d cycles, want %b/%h after 32", i, x, y, ALUFlags, Result, n, e[35:32], e[31:0]);
      end
    end
    step;
  endtask

  task automatic test_abort;
    bit spurious = 0;
    drive(3'd5, 32'd3, 32'd5);
    step;
    start = 1'b0;
    repeat (10) step;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({Result, ALUFlags, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL abort_reset: got res=%h flags=%b busy=%b done=%b, want all zero", Result, ALUFlags, busy, done);
    end
    step;
    step;
    reset = 1'b0;
    repeat (40) begin
      step;
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL abort_no_done: done or busy seen after aborted multiply, want none");
    end
    drive(3'd3, 32'hFF00FF00, 32'h0F0F0F0F);
    exp_q.push_back({4'b1000, 32'hFF0FFF0F});
    step;
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || {ALUFlags, Result} !== e) begin
      errors++;
      $display("FAIL abort_or: got done=%b %b/%h, want done=1 %b/%h", done, ALUFlags, Result, e[35:32], e[31:0]);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_flags;
    test_mul;
    test_back_to_back;
    test_random;
    test_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
